// File: rtl/tex_lod_pkg.sv
// Shared types and helpers for the trilinear mip sequencer.
package tex_lod_pkg;

  localparam int LOD_FRAC_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    WAIT0,
    FETCH1,
    WAIT1,
    EMIT
  } seq_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba8_t;

  // Rounded 8-bit lerp: (a*(256-f) + b*f + 128) >> 8. The widest sum is
  // 255*256 + 128, so 17 bits never overflow.
  function automatic logic [7:0] lerp8(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] f);
    logic [16:0] acc;
    acc = {9'd0, a} * (17'd256 - {9'd0, f}) + {9'd0, b} * {9'd0, f} + 17'd128;
    return 8'(acc >> LOD_FRAC_BITS);
  endfunction

endpackage

// File: rtl/texel_lerp4.sv
// Combinational per-channel blend of two RGBA8 texels by an 8-bit weight.
module texel_lerp4
  import tex_lod_pkg::*;
(
  input  logic [31:0] t0,
  input  logic [31:0] t1,
  input  logic [7:0]  f,
  output logic [31:0] texel
);

  rgba8_t c0;
  rgba8_t c1;
  rgba8_t mix;

  // Blend each channel independently; f = 0 returns t0 unchanged.
  always_comb begin
    c0    = rgba8_t'(t0);
    c1    = rgba8_t'(t1);
    mix.r = lerp8(c0.r, c1.r, f);
    mix.g = lerp8(c0.g, c1.g, f);
    mix.b = lerp8(c0.b, c1.b, f);
    mix.a = lerp8(c0.a, c1.a, f);
    texel = 32'(mix);
  end

endmodule

// File: rtl/trilinear_mip_sequencer.sv
// Per-fragment mip-level sequencer: bias/clamp the LOD, issue one or two
// bilinear fetches, then blend the returned texels by the LOD fraction.
module trilinear_mip_sequencer
  import tex_lod_pkg::*;
#(
  parameter int LEVELS = 12,
  parameter int TAGW   = 6,
  localparam int LW    = $clog2(LEVELS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [LW-1:0]   req_lod_int,
  input  logic [7:0]      req_lod_frac,
  input  logic [TAGW-1:0] req_tag,
  input  logic [LW+8:0]   cfg_bias,
  input  logic [LW+7:0]   cfg_min_lod,
  input  logic [LW+7:0]   cfg_max_lod,
  input  logic            cfg_trilin,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [LW-1:0]   fetch_level,
  output logic [TAGW-1:0] fetch_tag,
  input  logic            resp_valid,
  input  logic [31:0]     resp_texel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_texel,
  output logic [TAGW-1:0] out_tag,
  output logic            err_sticky
);

  localparam int SW = LW + 10;
  localparam logic signed [SW-1:0] LAM_TOP = SW'((LEVELS - 1) * 256);
  localparam logic [LW-1:0]        LVL_TOP = LW'(LEVELS - 1);

  seq_state_t state, state_nxt;

  logic signed [SW-1:0] lam_raw, lam_lo, lam_hi, lam_c, min_s, max_s;
  logic [LW+7:0]        lam_u;
  logic [LW-1:0]        lam_int;
  logic [7:0]           lam_frac;
  logic [LW:0]          near_sum;
  logic [LW-1:0]        sel_level;
  logic [7:0]           sel_frac;
  logic                 sel_dual;

  logic [LW-1:0]   level_q;
  logic [7:0]      frac_q;
  logic            dual_q;
  logic [TAGW-1:0] tag_q;
  logic [31:0]     t0_q;
  logic [31:0]     t1_q;
  logic            err_q;
  logic [31:0]     blend;
  logic            accept;
  logic            in_wait;

  // Bias, user clamps (max applied last so it wins), then the legal range.
  always_comb begin
    min_s   = $signed({2'b00, cfg_min_lod});
    max_s   = $signed({2'b00, cfg_max_lod});
    lam_raw = $signed({2'b00, req_lod_int, req_lod_frac})
            + $signed({cfg_bias[LW+8], cfg_bias});
    lam_lo  = (lam_raw < min_s) ? min_s : lam_raw;
    lam_hi  = (lam_lo > max_s) ? max_s : lam_lo;
    if (lam_hi < 0)
      lam_c = '0;
    else if (lam_hi > LAM_TOP)
      lam_c = LAM_TOP;
    else
      lam_c = lam_hi;
    lam_u    = (LW+8)'(lam_c);
    lam_int  = lam_u[LW+7:8];
    lam_frac = lam_u[7:0];
  end

  // Level selection: nearest rounds to the closest level, trilinear pairs
  // the floor level with the next one unless the weight is zero or at the top.
  always_comb begin
    near_sum = {1'b0, lam_int} + (LW+1)'(lam_frac[7]);
    if (cfg_trilin) begin
      sel_level = lam_int;
      sel_frac  = lam_frac;
      sel_dual  = (lam_frac != 8'd0) && (lam_int < LVL_TOP);
    end else begin
      sel_level = (near_sum > {1'b0, LVL_TOP}) ? LVL_TOP : near_sum[LW-1:0];
      sel_frac  = 8'd0;
      sel_dual  = 1'b0;
    end
  end

  texel_lerp4 u_lerp (
    .t0    (t0_q),
    .t1    (t1_q),
    .f     (frac_q),
    .texel (blend)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_nxt   = state;
    req_ready   = 1'b0;
    fetch_valid = 1'b0;
    out_valid   = 1'b0;
    fetch_level = level_q;
    accept      = 1'b0;
    in_wait     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid)
          state_nxt = FETCH0;
      end
      FETCH0: begin
        fetch_valid = 1'b1;
        if (fetch_ready)
          state_nxt = WAIT0;
      end
      WAIT0: begin
        in_wait = 1'b1;
        if (resp_valid)
          state_nxt = dual_q ? FETCH1 : EMIT;
      end
      FETCH1: begin
        fetch_valid = 1'b1;
        fetch_level = level_q + LW'(1);
        if (fetch_ready)
          state_nxt = WAIT1;
      end
      WAIT1: begin
        in_wait = 1'b1;
        if (resp_valid)
          state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fragment context captured at accept, texel capture in the wait states,
  // and the sticky error for stray responses.
  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset too, so outputs read zero out of
    // reset rather than X; they are few and cheap.
    if (rst) begin
      level_q <= '0;
      frac_q  <= '0;
      dual_q  <= 1'b0;
      tag_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        level_q <= sel_level;
        frac_q  <= sel_frac;
        dual_q  <= sel_dual;
        tag_q   <= req_tag;
      end
      if (state == WAIT0 && resp_valid)
        t0_q <= resp_texel;
      if (state == WAIT1 && resp_valid)
        t1_q <= resp_texel;
      if (resp_valid && !in_wait)
        err_q <= 1'b1;
    end
  end

  assign fetch_tag  = tag_q;
  assign out_tag    = tag_q;
  assign out_texel  = dual_q ? blend : t0_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_trilinear_mip_sequencer.sv
// Directed self-checking bench for trilinear_mip_sequencer.
module tb_trilinear_mip_sequencer;

  localparam int LEVELS = 12;
  localparam int TAGW   = 6;
  localparam int LW     = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [LW-1:0]   req_lod_int = '0;
  logic [7:0]      req_lod_frac = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic [LW+8:0]   cfg_bias = '0;
  logic [LW+7:0]   cfg_min_lod = '0;
  logic [LW+7:0]   cfg_max_lod = '1;
  logic            cfg_trilin = 1'b0;
  logic            fetch_valid;
  logic            fetch_ready = 1'b0;
  logic [LW-1:0]   fetch_level;
  logic [TAGW-1:0] fetch_tag;
  logic            resp_valid = 1'b0;
  logic [31:0]     resp_texel = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_texel;
  logic [TAGW-1:0] out_tag;
  logic            err_sticky;

  trilinear_mip_sequencer #(.LEVELS(LEVELS), .TAGW(TAGW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_lod_int  (req_lod_int),
    .req_lod_frac (req_lod_frac),
    .req_tag      (req_tag),
    .cfg_bias     (cfg_bias),
    .cfg_min_lod  (cfg_min_lod),
    .cfg_max_lod  (cfg_max_lod),
    .cfg_trilin   (cfg_trilin),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_level  (fetch_level),
    .fetch_tag    (fetch_tag),
    .resp_valid   (resp_valid),
    .resp_texel   (resp_texel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_texel    (out_texel),
    .out_tag      (out_tag),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of one fragment, straight from the LOD/blend rules.
  task automatic model(input int li, input int lf, input int bias, input int mn, input int mx,
                       input bit trilin, input logic [31:0] t0, input logic [31:0] t1,
                       output int n, output int l0, output logic [31:0] tex);
    int lam;
    int f;
    lam = li * 256 + lf + bias;
    if (lam < mn) lam = mn;
    if (lam > mx) lam = mx;
    if (lam < 0) lam = 0;
    if (lam > (LEVELS - 1) * 256) lam = (LEVELS - 1) * 256;
    if (trilin) begin
      l0 = lam / 256;
      f  = lam % 256;
      n  = (f != 0 && l0 < LEVELS - 1) ? 2 : 1;
    end else begin
      l0 = (lam + 128) / 256;
      if (l0 > LEVELS - 1) l0 = LEVELS - 1;
      f  = 0;
      n  = 1;
    end
    if (n == 1) begin
      tex = t0;
    end else begin
      tex = '0;
      for (int c = 0; c < 4; c++) begin
        int a;
        int b;
        a = int'((t0 >> (8 * c)) & 32'hFF);
        b = int'((t1 >> (8 * c)) & 32'hFF);
        tex = tex | (32'(((a * (256 - f) + b * f + 128) / 256)) << (8 * c));
      end
    end
  endtask

  // Expectations shared between the driver and the compare process.
  bit              mon_en = 1'b0;
  int              exp_n;
  int              exp_lvl [2];
  logic [31:0]     exp_texel;
  logic [TAGW-1:0] exp_tag;
  int              base_f;
  int              base_o;
  int              fetch_total = 0;
  int              out_total   = 0;
  int              got_lvl [2];
  logic [31:0]     got_texel;

  // Compare process: every cycle a fetch or output is presented, it must match.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fetch_valid) begin
        int k;
        k = fetch_total - base_f;
        check("fetch_in_budget", 32'(k < exp_n), 32'd1);
        if (k < 2) begin
          check("fetch_level", 32'(fetch_level), 32'(exp_lvl[k]));
          got_lvl[k] = int'(fetch_level);
        end
        check("fetch_tag", 32'(fetch_tag), 32'(exp_tag));
        if (fetch_ready) fetch_total++;
      end
      if (out_valid) begin
        check("out_texel", out_texel, exp_texel);
        check("out_tag", 32'(out_tag), 32'(exp_tag));
        got_texel = out_texel;
        if (out_ready) out_total++;
      end
    end
  end

  task automatic run_frag(input int li, input int lf, input int bias, input int mn, input int mx,
                          input bit trilin, input logic [TAGW-1:0] tag,
                          input logic [31:0] t0, input logic [31:0] t1,
                          input int fr_hold, input int out_hold);
    int n;
    int l0;
    logic [31:0] tex;
    int waitc;
    int acc_cyc;
    model(li, lf, bias, mn, mx, trilin, t0, t1, n, l0, tex);
    exp_n      = n;
    exp_lvl[0] = l0;
    exp_lvl[1] = l0 + 1;
    exp_texel  = tex;
    exp_tag    = tag;
    base_f     = fetch_total;
    base_o     = out_total;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    cfg_bias     = (LW+9)'(bias);
    cfg_min_lod  = (LW+8)'(mn);
    cfg_max_lod  = (LW+8)'(mx);
    cfg_trilin   = trilin;
    req_lod_int  = LW'(li);
    req_lod_frac = 8'(lf);
    req_tag      = tag;
    req_valid    = 1'b1;
    acc_cyc      = cyc;
    @(posedge clk); #1;
    req_valid   = 1'b0;
    // Scrambled config after accept must not affect this fragment.
    cfg_trilin  = ~trilin;
    cfg_bias    = (LW+9)'(-256);
    cfg_max_lod = '0;
    req_tag     = ~tag;
    for (int k = 0; k < n; k++) begin
      waitc = 0;
      while (!fetch_valid && waitc < 50) begin
        @(posedge clk); #1;
        waitc++;
      end
      check("fetch_seen", 32'(fetch_valid), 32'd1);
      for (int h = 0; h < fr_hold; h++) begin
        @(posedge clk); #1;
        check("fetch_held", 32'(fetch_valid), 32'd1);
      end
      fetch_ready = 1'b1;
      @(posedge clk); #1;
      fetch_ready = 1'b0;
      resp_valid  = 1'b1;
      resp_texel  = (k == 0) ? t0 : t1;
      @(posedge clk); #1;
      resp_valid  = 1'b0;
      resp_texel  = $urandom;
    end
    waitc = 0;
    while (!out_valid && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("out_seen", 32'(out_valid), 32'd1);
    if (fr_hold == 0) check("latency", 32'(cyc - acc_cyc), (n == 2) ? 32'd5 : 32'd3);
    for (int h = 0; h < out_hold; h++) begin
      @(posedge clk); #1;
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("out_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("fetch_count", 32'(fetch_total - base_f), 32'(n));
    check("out_count", 32'(out_total - base_o), 32'd1);
    check("idle_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_texel", out_texel, 32'd0);
    check("rst_fetch_level", 32'(fetch_level), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    mon_en = 1'b1;

    // Trilinear, black to white at quarter weight.
    run_frag(2, 8'h40, 0, 0, 12'hFFF, 1'b1, 6'h11, 32'h00000000, 32'hFFFFFFFF, 0, 0);
    check("t1_lvl0", 32'(got_lvl[0]), 32'd2);
    check("t1_lvl1", 32'(got_lvl[1]), 32'd3);
    check("t1_texel", got_texel, 32'h40404040);

    // Nearest rounds 3.5 up to level 4, texel passes through.
    run_frag(3, 8'h80, 0, 0, 12'hFFF, 1'b0, 6'h22, 32'h12345678, 32'hDEADBEEF, 0, 0);
    check("t2_lvl", 32'(got_lvl[0]), 32'd4);
    check("t2_texel", got_texel, 32'h12345678);

    // Negative LOD clamps to level 0; top level never pairs.
    run_frag(1, 0, -12'h300, 0, 12'hFFF, 1'b1, 6'h05, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0);
    check("t3a_lvl", 32'(got_lvl[0]), 32'd0);
    run_frag(11, 8'h80, 0, 0, 12'hFFF, 1'b1, 6'h06, 32'hCAFEF00D, 32'h01020304, 0, 0);
    check("t3b_lvl", 32'(got_lvl[0]), 32'd11);
    check("t3b_texel", got_texel, 32'hCAFEF00D);

    // Max clamp to 2.5, with fetch and output back-pressure.
    run_frag(5, 0, 0, 0, 12'h280, 1'b1, 6'h33, 32'h10203040, 32'h30405060, 4, 3);
    check("t4_lvl0", 32'(got_lvl[0]), 32'd2);
    check("t4_lvl1", 32'(got_lvl[1]), 32'd3);
    check("t4_texel", got_texel, 32'h20304050);

    // Extra points: min above max, min clamp, positive bias, rounding.
    run_frag(1, 0, 0, 12'h500, 12'h300, 1'b1, 6'h01, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 0);
    check("minmax_lvl", 32'(got_lvl[0]), 32'd3);
    run_frag(0, 8'h10, 0, 12'h150, 12'hFFF, 1'b1, 6'h02, 32'hFF00FF00, 32'h00FF00FF, 0, 1);
    run_frag(7, 8'h01, 12'h0FF, 0, 12'hFFF, 1'b1, 6'h03, 32'h11223344, 32'h55667788, 0, 0);
    run_frag(0, 8'hC0, -12'h40, 0, 12'hFFF, 1'b1, 6'h04, 32'h000000FF, 32'hFF000000, 1, 0);
    run_frag(10, 8'h7F, 0, 0, 12'hFFF, 1'b0, 6'h07, 32'h89ABCDEF, 32'h0, 2, 2);
    mon_en = 1'b0;

    // Stray response while idle.
    resp_valid = 1'b1;
    resp_texel = 32'hBADBAD00;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    check("stray_err", 32'(err_sticky), 32'd1);
    check("stray_req_ready", 32'(req_ready), 32'd1);
    check("stray_fetch_valid", 32'(fetch_valid), 32'd0);
    check("stray_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("err_cleared", 32'(err_sticky), 32'd0);

    // Reset while waiting for the second response.
    cfg_trilin   = 1'b1;
    cfg_bias     = '0;
    cfg_min_lod  = '0;
    cfg_max_lod  = '1;
    req_lod_int  = 4'd2;
    req_lod_frac = 8'h40;
    req_tag      = 6'h2A;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("w1_fetch0", 32'(fetch_valid), 32'd1);
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    resp_valid  = 1'b1;
    resp_texel  = 32'h01010101;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    check("w1_fetch1", 32'(fetch_valid), 32'd1);
    check("w1_level1", 32'(fetch_level), 32'd3);
    fetch_ready = 1'b1;
    @(posedge clk); #1;
    fetch_ready = 1'b0;
    check("w1_waiting", 32'(fetch_valid | out_valid | req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("w1_rst_req_ready", 32'(req_ready), 32'd1);
    check("w1_rst_out_valid", 32'(out_valid), 32'd0);
    mon_en = 1'b1;
    run_frag(4, 8'hC0, 0, 0, 12'hFFF, 1'b1, 6'h3F, 32'h40404040, 32'h80808080, 0, 0);
    check("w1_after_lvl0", 32'(got_lvl[0]), 32'd4);
    check("w1_after_texel", got_texel, 32'h70707070);
    check("final_err", 32'(err_sticky), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
